// File: rtl/integral_sched.sv
// Issue sequencer for the 4-lane power-integral datapath: walks FFT column pairs
// per frame, gates issue on sink credits, aligns strobes and tracks results.
module integral_sched #(
  parameter int NUM_COLS = 2048,
  parameter int IDX_W    = 11,
  parameter int SRC_LAT  = 2,
  parameter int DP_LAT   = 3,
  parameter int CREDITS  = 8,
  parameter int FRM_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [FRM_W-1:0] num_frames,
  input  logic             src_frame_valid,
  output logic             src_frame_ack,
  output logic             src_rd_en,
  output logic [IDX_W-1:0] src_rd_col1,
  output logic [IDX_W-1:0] src_rd_col2,
  output logic             dp_valid,
  output logic [IDX_W-1:0] dp_index_col1,
  output logic [IDX_W-1:0] dp_index_col2,
  input  logic             dp_ready,
  input  logic             sink_credit_ret,
  output logic             out_first,
  output logic [FRM_W-1:0] frame_idx,
  output logic             busy,
  output logic             done,
  output logic             abort_done,
  output logic [1:0]       dbg_state_o
);

  // Handshake semantics: src_rd_en, dp_valid and dp_ready are single-cycle
  // strobes with no backpressure. Flow control is purely credit based: a pair
  // is issued only while credits > 0, and each dp_valid yields exactly one
  // dp_ready DP_LAT cycles later.

  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam int INF_W = $clog2(CREDITS + SRC_LAT + DP_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_P    = IDX_W'(NUM_COLS / 2);
  // NUM_COLS is a power of two, so NUM_COLS+1-p taken modulo NUM_COLS is 1-p.
  localparam logic [IDX_W-1:0] COL2_BASE = IDX_W'(NUM_COLS + 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_ISSUE      = 2'd2,
    S_DRAIN      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] p_q, p_d;
  logic [FRM_W-1:0] frame_idx_q, frame_idx_d;
  logic [FRM_W-1:0] frames_q, frames_d;
  logic [CRD_W-1:0] credits_q, credits_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             abort_flag_q, abort_flag_d;
  logic             done_q, done_d;
  logic             abort_done_q, abort_done_d;

  logic [SRC_LAT-1:0]            v_pipe_q;
  logic [SRC_LAT-1:0]            f_pipe_q;
  logic [SRC_LAT-1:0][IDX_W-1:0] c1_pipe_q;
  logic [SRC_LAT-1:0][IDX_W-1:0] c2_pipe_q;
  logic [DP_LAT-1:0]             fd_pipe_q;

  logic             issue;
  logic             last_pair;
  logic             more_frames;
  logic [IDX_W-1:0] pair_col2;

  // Abort suppresses issue in the very cycle it is seen.
  assign issue       = (state_q == S_ISSUE) && (credits_q != '0) && !abort;
  assign last_pair   = (p_q == LAST_P);
  assign more_frames = ({1'b0, frame_idx_q} + (FRM_W + 1)'(1)) < {1'b0, frames_q};
  assign pair_col2   = (p_q < IDX_W'(2)) ? '0 : (COL2_BASE - p_q);

  assign src_rd_en     = issue;
  assign src_rd_col1   = issue ? p_q : '0;
  assign src_rd_col2   = issue ? pair_col2 : '0;
  assign src_frame_ack = issue && last_pair;

  assign dp_valid      = v_pipe_q[SRC_LAT-1];
  assign dp_index_col1 = c1_pipe_q[SRC_LAT-1];
  assign dp_index_col2 = c2_pipe_q[SRC_LAT-1];
  assign out_first     = fd_pipe_q[DP_LAT-1] && dp_ready;

  assign frame_idx   = frame_idx_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign abort_done  = abort_done_q;
  assign dbg_state_o = state_q;

  always_comb begin
    credits_d = credits_q;
    if (issue && !sink_credit_ret) begin
      credits_d = credits_q - CRD_W'(1);
    end else if (!issue && sink_credit_ret && (credits_q < CRD_W'(CREDITS))) begin
      credits_d = credits_q + CRD_W'(1);
    end
    inflight_d = inflight_q;
    if (issue && !dp_ready) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!issue && dp_ready && (inflight_q != '0)) begin
      inflight_d = inflight_q - INF_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    frame_idx_d  = frame_idx_q;
    frames_d     = frames_q;
    abort_flag_d = abort_flag_q;
    done_d       = 1'b0;
    abort_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WAIT_FRAME;
          frames_d     = (num_frames == '0) ? FRM_W'(1) : num_frames;
          frame_idx_d  = '0;
          p_d          = '0;
          abort_flag_d = 1'b0;
        end
      end
      S_WAIT_FRAME: begin
        if (abort) begin
          state_d      = S_DRAIN;
          abort_flag_d = 1'b1;
        end else if (src_frame_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d      = S_DRAIN;
          abort_flag_d = 1'b1;
        end else if (issue) begin
          if (last_pair) begin
            p_d = '0;
            if (more_frames) begin
              frame_idx_d = frame_idx_q + FRM_W'(1);
              state_d     = S_WAIT_FRAME;
            end else begin
              state_d = S_DRAIN;
            end
          end else begin
            p_d = p_q + IDX_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          abort_flag_d = 1'b1;
        end
        // Looking at the post-update count lets done land one cycle after
        // the final dp_ready.
        if (inflight_d == '0) begin
          state_d      = S_IDLE;
          frame_idx_d  = '0;
          abort_flag_d = 1'b0;
          if (abort_flag_q || abort) begin
            abort_done_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      p_q          <= '0;
      frame_idx_q  <= '0;
      frames_q     <= '0;
      credits_q    <= CRD_W'(CREDITS);
      inflight_q   <= '0;
      abort_flag_q <= 1'b0;
      done_q       <= 1'b0;
      abort_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      frame_idx_q  <= frame_idx_d;
      frames_q     <= frames_d;
      credits_q    <= credits_d;
      inflight_q   <= inflight_d;
      abort_flag_q <= abort_flag_d;
      done_q       <= done_d;
      abort_done_q <= abort_done_d;
    end
  end

  // Source-read alignment pipe, then the "first" tag rides on to the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe_q  <= '0;
      f_pipe_q  <= '0;
      c1_pipe_q <= '0;
      c2_pipe_q <= '0;
      fd_pipe_q <= '0;
    end else begin
      for (int i = SRC_LAT - 1; i > 0; i--) begin
        v_pipe_q[i]  <= v_pipe_q[i-1];
        f_pipe_q[i]  <= f_pipe_q[i-1];
        c1_pipe_q[i] <= c1_pipe_q[i-1];
        c2_pipe_q[i] <= c2_pipe_q[i-1];
      end
      v_pipe_q[0]  <= issue;
      f_pipe_q[0]  <= issue && (frame_idx_q == '0);
      c1_pipe_q[0] <= src_rd_col1;
      c2_pipe_q[0] <= src_rd_col2;
      for (int j = DP_LAT - 1; j > 0; j--) begin
        fd_pipe_q[j] <= fd_pipe_q[j-1];
      end
      fd_pipe_q[0] <= v_pipe_q[SRC_LAT-1] && f_pipe_q[SRC_LAT-1];
    end
  end

endmodule

// File: tb/tb_integral_sched.sv
// Bench for integral_sched with NUM_COLS=8: directed jobs, a datapath/source
// model, and a scoreboard of expected issues, datapath strobes and results.
module tb_integral_sched;

  localparam int NUM_COLS = 8;
  localparam int IDX_W    = 3;
  localparam int SRC_LAT  = 2;
  localparam int DP_LAT   = 3;
  localparam int CREDITS  = 8;
  localparam int FRM_W    = 8;

  // Hand-computed pair table for NUM_COLS=8.
  localparam logic [2:0] EXP_C1 [0:4] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  localparam logic [2:0] EXP_C2 [0:4] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd5};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [FRM_W-1:0] num_frames = '0;
  logic             src_frame_valid = 1'b0;
  logic             dp_ready = 1'b0;
  logic             sink_credit_ret = 1'b0;
  logic             src_frame_ack, src_rd_en, dp_valid, out_first;
  logic             busy, done, abort_done;
  logic [IDX_W-1:0] src_rd_col1, src_rd_col2, dp_index_col1, dp_index_col2;
  logic [FRM_W-1:0] frame_idx;
  logic [1:0]       dbg_state;

  integral_sched #(
    .NUM_COLS(NUM_COLS), .IDX_W(IDX_W), .SRC_LAT(SRC_LAT),
    .DP_LAT(DP_LAT), .CREDITS(CREDITS), .FRM_W(FRM_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_frames(num_frames), .src_frame_valid(src_frame_valid),
    .src_frame_ack(src_frame_ack), .src_rd_en(src_rd_en),
    .src_rd_col1(src_rd_col1), .src_rd_col2(src_rd_col2),
    .dp_valid(dp_valid), .dp_index_col1(dp_index_col1),
    .dp_index_col2(dp_index_col2), .dp_ready(dp_ready),
    .sink_credit_ret(sink_credit_ret), .out_first(out_first),
    .frame_idx(frame_idx), .busy(busy), .done(done),
    .abort_done(abort_done), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [14:0] exp_iss_q[$];
  logic [5:0]  exp_dp_q[$];
  logic [0:0]  exp_res_q[$];
  int          iss_cyc_q[$];
  int n_iss = 0, n_done = 0, n_ad = 0;
  int last_rdy_cyc = 0, done_cyc = 0, ad_cyc = 0;

  // ---------------- model controls ----------------
  bit src_on = 1'b0;
  bit credit_auto = 1'b0;
  bit gap_en = 1'b0;
  int ret_req = 0;
  int ret_given = 0;
  bit gap_pend = 1'b0;
  int gap_cnt = 0;
  logic [DP_LAT-1:0] vq = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath, source-frame and sink models, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      vq       = '0;
      dp_ready = 1'b0;
    end else begin
      dp_ready = vq[DP_LAT-1];
      vq       = {vq[DP_LAT-2:0], dp_valid};
    end
    if (ret_given < ret_req) begin
      sink_credit_ret = 1'b1;
      ret_given++;
    end else begin
      sink_credit_ret = credit_auto;
    end
    if (gap_pend) begin
      gap_pend = 1'b0;
      gap_cnt  = 4;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    if (gap_en && src_frame_ack) gap_pend = 1'b1;
    src_frame_valid = src_on && (gap_cnt == 0);
  end

  // Monitor: pops expectations whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (rst) begin
      exp_iss_q.delete();
      exp_dp_q.delete();
      exp_res_q.delete();
      iss_cyc_q.delete();
    end else begin
      if (src_rd_en) begin
        n_iss++;
        iss_cyc_q.push_back(cyc);
        if (exp_iss_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL issue_extra: actual col1=%0d col2=%0d required no issue", src_rd_col1, src_rd_col2);
        end else begin
          chk("issue{frame,ack,col1,col2}", 32'({frame_idx, src_frame_ack, src_rd_col1, src_rd_col2}),
              32'(exp_iss_q.pop_front()));
        end
      end
      if (dp_valid) begin
        if (exp_dp_q.size() == 0 || iss_cyc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dp_extra: actual dp_valid=1 required no datapath strobe");
        end else begin
          chk("dp_index", 32'({dp_index_col1, dp_index_col2}), 32'(exp_dp_q.pop_front()));
          chk("dp_latency", 32'(cyc - iss_cyc_q.pop_front()), 32'(SRC_LAT));
        end
      end
      if (dp_ready) begin
        last_rdy_cyc = cyc;
        if (exp_res_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL result_extra: actual dp_ready=1 required no result");
        end else begin
          chk("out_first", 32'(out_first), 32'(exp_res_q.pop_front()));
        end
      end else if (out_first) begin
        n_cmp++; n_bad++;
        $display("FAIL out_first_unqualified: actual 1 required 0");
      end
      if (gap_cnt > 0) chk("gap_no_issue", 32'(src_rd_en), 32'(0));
      if (done) begin n_done++; done_cyc = cyc; end
      if (abort_done) begin n_ad++; ad_cyc = cyc; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_job(input int nf, input int limit);
    int cnt;
    cnt = 0;
    for (int f = 0; f < nf; f++) begin
      for (int p = 0; p < 5; p++) begin
        if (cnt < limit) begin
          logic [7:0] fi;
          fi = f[7:0];
          exp_iss_q.push_back({fi, (p == 4), EXP_C1[p], EXP_C2[p]});
          exp_dp_q.push_back({EXP_C1[p], EXP_C2[p]});
          exp_res_q.push_back(f == 0);
          cnt++;
        end
      end
    end
  endtask

  task automatic start_job(input logic [FRM_W-1:0] nf, input logic with_abort);
    @(posedge clk); #1;
    chk("busy_before_start", 32'(busy), 32'(0));
    num_frames = nf;
    start      = 1'b1;
    abort      = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("busy_cycle_after_start", 32'(busy), 32'(1));
  endtask

  task automatic wait_end(input int budget, input string name);
    int k;
    k = 0;
    while (!(done || abort_done) && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual no done/abort_done in %0d cycles required completion", name, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_iss(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_iss < target && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual %0d issues required %0d", name, n_iss, target);
    end
  endtask

  task automatic check_empty(input string name);
    chk({name, "_issue_left"},  32'(exp_iss_q.size()), 32'(0));
    chk({name, "_dp_left"},     32'(exp_dp_q.size()),  32'(0));
    chk({name, "_result_left"}, 32'(exp_res_q.size()), 32'(0));
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_rd_en"},   32'(src_rd_en), 32'(0));
    chk({name, "_rd_cols"}, 32'({src_rd_col1, src_rd_col2}), 32'(0));
    chk({name, "_ack"},     32'(src_frame_ack), 32'(0));
    chk({name, "_dp"},      32'({dp_valid, dp_index_col1, dp_index_col2}), 32'(0));
    chk({name, "_first"},   32'(out_first), 32'(0));
    chk({name, "_frame"},   32'(frame_idx), 32'(0));
    chk({name, "_busy"},    32'(busy), 32'(0));
    chk({name, "_done"},    32'({done, abort_done}), 32'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    int b_iss, b_done, b_ad;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    src_on = 1'b1;
    credit_auto = 1'b1;
    repeat (3) @(posedge clk);

    // Single frame; a second start while busy must be ignored.
    b_iss = n_iss; b_done = n_done; b_ad = n_ad;
    push_job(1, 5);
    start_job(8'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_end(100, "single");
    chk("single_issues", 32'(n_iss - b_iss), 32'(5));
    chk("single_done_count", 32'(n_done - b_done), 32'(1));
    chk("single_abort_done_count", 32'(n_ad - b_ad), 32'(0));
    chk("single_done_after_last_ready", 32'(done_cyc - last_rdy_cyc), 32'(1));
    chk("single_busy_low", 32'(busy), 32'(0));
    check_empty("single");
    repeat (5) @(posedge clk);

    // Three frames with a 4-cycle source gap after each frame.
    gap_en = 1'b1;
    b_iss = n_iss; b_done = n_done;
    push_job(3, 15);
    start_job(8'd3, 1'b0);
    wait_end(300, "multi");
    chk("multi_issues", 32'(n_iss - b_iss), 32'(15));
    chk("multi_done_count", 32'(n_done - b_done), 32'(1));
    check_empty("multi");
    gap_en = 1'b0;
    repeat (8) @(posedge clk);

    // num_frames=0 behaves as one frame; start with abort in IDLE: start wins.
    b_iss = n_iss; b_done = n_done; b_ad = n_ad;
    push_job(1, 5);
    start_job(8'd0, 1'b1);
    wait_end(100, "zero_frames");
    chk("zero_frames_issues", 32'(n_iss - b_iss), 32'(5));
    chk("zero_frames_done_count", 32'(n_done - b_done), 32'(1));
    chk("zero_frames_abort_done_count", 32'(n_ad - b_ad), 32'(0));
    check_empty("zero_frames");
    repeat (5) @(posedge clk);

    // Abort during the third issue cycle.
    b_iss = n_iss; b_done = n_done; b_ad = n_ad;
    push_job(1, 2);
    start_job(8'd1, 1'b0);
    wait_iss(b_iss + 2, 50, "abort_wait");
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    wait_end(100, "abort");
    chk("abort_issues", 32'(n_iss - b_iss), 32'(2));
    chk("abort_done_count", 32'(n_ad - b_ad), 32'(1));
    chk("abort_no_done", 32'(n_done - b_done), 32'(0));
    chk("abort_done_after_last_ready", 32'(ad_cyc - last_rdy_cyc), 32'(1));
    check_empty("abort");
    repeat (5) @(posedge clk);

    // Reset mid-ISSUE with three pairs in flight and no credits returned.
    credit_auto = 1'b0;
    b_done = n_done; b_ad = n_ad;
    push_job(1, 5);
    start_job(8'd1, 1'b0);
    wait_iss(n_iss + 3, 50, "reset_wait");
    @(posedge clk); #1; rst = 1'b1;
    #1;
    check_outputs_zero("midjob_reset");
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_no_done", 32'(n_done - b_done), 32'(0));
    chk("reset_no_abort_done", 32'(n_ad - b_ad), 32'(0));
    check_empty("reset");

    // Credit exhaustion: restored credits allow exactly CREDITS issues.
    b_iss = n_iss; b_done = n_done;
    push_job(3, 15);
    start_job(8'd3, 1'b0);
    repeat (40) @(negedge clk);
    chk("credit_stall", 32'(n_iss - b_iss), 32'(CREDITS));
    ret_req = ret_req + 1;
    repeat (15) @(negedge clk);
    chk("credit_one_return", 32'(n_iss - b_iss), 32'(CREDITS + 1));
    ret_req = ret_req + 2;
    repeat (15) @(negedge clk);
    chk("credit_return_with_issue", 32'(n_iss - b_iss), 32'(CREDITS + 3));
    credit_auto = 1'b1;
    wait_end(200, "credit");
    chk("credit_total_issues", 32'(n_iss - b_iss), 32'(15));
    chk("credit_done_count", 32'(n_done - b_done), 32'(1));
    check_empty("credit");
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
